// File: rtl/prism_config_loader_if.sv
// Debug-bus write/readback port plus the latch-bank side outputs of the config loader.
interface prism_config_loader_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) ();
  logic             debug_wr;
  logic [5:0]       address;
  logic [31:0]      data_in;
  logic [31:0]      rd_data;
  logic [WIDTH-1:0] config_data;
  logic [DEPTH-1:0] latch_en;
  logic             busy;
  logic             done;

  modport master (
    output debug_wr, address, data_in,
    input  rd_data, config_data, latch_en, busy, done
  );

  modport slave (
    input  debug_wr, address, data_in,
    output rd_data, config_data, latch_en, busy, done
  );
endinterface

// File: rtl/prism_config_loader.sv
// Stages a WIDTH-bit config word from the debug bus and strobes it into one latch entry or a
// descending range of entries, EN_CYCLES clocks per entry; status/err readback at 6'h14.
module prism_config_loader #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 64,
  parameter int EN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prism_config_loader_if.slave  bus
);
  localparam int NWORDS   = WIDTH / 32;
  localparam int IDX_BITS = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state, state_nx;
  logic [31:0]      stage [NWORDS];
  logic [4:0]       idx, idx_nx, start_q, start_nx;
  logic [3:0]       cnt, cnt_nx;
  logic             err, err_nx, err_set;
  logic             done, done_nx;
  logic [DEPTH-1:0] latch_en, latch_en_nx;

  logic       wr_ctrl, wr_stat, wr_stage, idle;
  logic [2:0] stage_k;
  logic [4:0] ctl_start, ctl_end;
  logic       ctl_sweep, ctl_abort, ctl_ok;

  assign idle      = (state == IDLE);
  assign stage_k   = bus.address[4:2];
  assign wr_ctrl   = bus.debug_wr && (bus.address == 6'h10);
  assign wr_stat   = bus.debug_wr && (bus.address == 6'h14);
  assign wr_stage  = bus.debug_wr && bus.address[5] && (bus.address[1:0] == 2'b00)
                     && (int'(stage_k) < NWORDS);
  assign ctl_start = bus.data_in[4:0];
  assign ctl_end   = bus.data_in[12:8];
  assign ctl_sweep = bus.data_in[16];
  assign ctl_abort = bus.data_in[31];
  assign ctl_ok    = ctl_sweep ? ((ctl_start <= ctl_end) && ({1'b0, ctl_end} < 6'(DEPTH)))
                               : ({1'b0, ctl_start} < 6'(DEPTH));

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    start_nx = start_q;
    cnt_nx   = cnt;
    err_set  = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ctrl && !ctl_abort) begin
          if (ctl_ok) begin
            start_nx = ctl_start;
            idx_nx   = ctl_sweep ? ctl_end : ctl_start;
            state_nx = SETUP;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      SETUP: begin
        state_nx = STROBE;
        cnt_nx   = 4'(EN_CYCLES - 1);
      end
      STROBE: begin
        if (cnt == 4'd0) state_nx = HOLD;
        else             cnt_nx   = cnt - 4'd1;
      end
      HOLD: begin
        if (idx == start_q) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          idx_nx   = idx - 5'd1;
          cnt_nx   = 4'(EN_CYCLES - 1);
          state_nx = STROBE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Bus traffic during a sequence: abort wins, anything else only flags err.
    if (!idle) begin
      if (wr_ctrl && ctl_abort) begin
        state_nx = IDLE;
        idx_nx   = idx;
        done_nx  = 1'b0;
      end else if (wr_ctrl || wr_stage) begin
        err_set = 1'b1;
      end
    end

    if (err_set)                         err_nx = 1'b1;
    else if (wr_stat && bus.data_in[31]) err_nx = 1'b0;
    else                                 err_nx = err;

    latch_en_nx = '0;
    if (state_nx == STROBE) latch_en_nx[idx_nx[IDX_BITS-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      start_q  <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      latch_en <= '0;
      for (int k = 0; k < NWORDS; k++) stage[k] <= '0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      start_q  <= start_nx;
      cnt      <= cnt_nx;
      err      <= err_nx;
      done     <= done_nx;
      latch_en <= latch_en_nx;
      for (int k = 0; k < NWORDS; k++) begin
        if (wr_stage && idle && (stage_k == 3'(k))) stage[k] <= bus.data_in;
      end
    end
  end

  for (genvar k = 0; k < NWORDS; k++) begin : g_cfg
    assign bus.config_data[32*k +: 32] = stage[k];
  end

  assign bus.latch_en = latch_en;
  assign bus.busy     = !idle;
  assign bus.done     = done;
  assign bus.rd_data  = (bus.address == 6'h14) ? {err, !idle, 25'd0, idx} : 32'd0;
endmodule

// File: tb/tb_prism_config_loader.sv
// Randomized self-checking bench for prism_config_loader against a cycle-trace reference model.
module tb_prism_config_loader;
  localparam int DEPTH = 8;
  localparam int WIDTH = 64;
  localparam int EN    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prism_config_loader_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  prism_config_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .EN_CYCLES(EN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_stage [2];
  logic        mdl_err;
  logic [4:0]  mdl_idx;

  function automatic logic [WIDTH-1:0] mdl_cfg();
    return {mdl_stage[1], mdl_stage[0]};
  endfunction

  // Called at a negedge; returns at the next negedge, one edge after the write was sampled.
  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    bus.debug_wr = 1'b1;
    bus.address  = a;
    bus.data_in  = d;
    @(negedge clk);
    bus.debug_wr = 1'b0;
    bus.address  = 6'h00;
    bus.data_in  = 32'd0;
  endtask

  task automatic read_status(output logic [31:0] v);
    bus.address = 6'h14;
    #1 v = bus.rd_data;
    bus.address = 6'h00;
  endtask

  task automatic do_reset();
    bus.debug_wr = 1'b0;
    bus.address  = 6'h00;
    bus.data_in  = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mdl_stage[0] = '0;
    mdl_stage[1] = '0;
    mdl_err = 1'b0;
    mdl_idx = '0;
  endtask

  task automatic stage_word(input int k, input logic [31:0] d);
    bus_write(6'(6'h20 + 4 * k), d);
    mdl_stage[k] = d;
  endtask

  // Commit a valid range and compare every cycle against the expected per-entry trace.
  task automatic run_seq(input logic [4:0] s, input logic [4:0] e, input bit sweep, input string tag);
    logic [DEPTH-1:0] q_le[$];
    bit               q_busy[$];
    logic [31:0]      st;
    int first, n;
    first = sweep ? int'(e) : int'(s);
    n     = sweep ? int'(e) - int'(s) + 1 : 1;
    q_le.push_back('0); q_busy.push_back(1'b1);
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < EN; c++) begin
        q_le.push_back(DEPTH'(1) << (first - j));
        q_busy.push_back(1'b1);
      end
      q_le.push_back('0); q_busy.push_back(1'b1);
    end
    q_le.push_back('0); q_busy.push_back(1'b0);
    bus_write(6'h10, {15'd0, sweep, 3'd0, e, 3'd0, s});
    for (int i = 0; i < q_le.size(); i++) begin
      checks++;
      if (bus.latch_en !== q_le[i] || bus.busy !== q_busy[i] ||
          bus.done !== (i == q_le.size() - 1)) begin
        errors++;
        $display("FAIL %s cyc%0d latch_en=%h busy=%b done=%b expected %h %b %b", tag, i,
                 bus.latch_en, bus.busy, bus.done, q_le[i], q_busy[i], i == q_le.size() - 1);
      end
      checks++;
      if (bus.config_data !== mdl_cfg()) begin
        errors++;
        $display("FAIL %s cfg cyc%0d got %h expected %h", tag, i, bus.config_data, mdl_cfg());
      end
      @(negedge clk);
    end
    mdl_idx = s;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after done=%b busy=%b expected 0 0", tag, bus.done, bus.busy);
    end
    read_status(st);
    checks++;
    if (st !== {mdl_err, 1'b0, 25'd0, mdl_idx}) begin
      errors++;
      $display("FAIL %s status got %h expected %h", tag, st, {mdl_err, 1'b0, 25'd0, mdl_idx});
    end
  endtask

  task automatic test_reset();
    logic [31:0] st;
    do_reset();
    read_status(st);
    checks++;
    if (bus.latch_en !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.config_data !== '0 || st !== 32'd0) begin
      errors++;
      $display("FAIL reset le=%h busy=%b done=%b cfg=%h st=%h expected all zero",
               bus.latch_en, bus.busy, bus.done, bus.config_data, st);
    end
  endtask

  task automatic test_single();
    stage_word(0, 32'hDEADBEEF);
    stage_word(1, 32'h12345678);
    checks++;
    if (bus.config_data !== 64'h12345678_DEADBEEF) begin
      errors++;
      $display("FAIL stage got %h expected 12345678deadbeef", bus.config_data);
    end
    run_seq(5'd3, 5'd0, 1'b0, "single3");
  endtask

  task automatic test_sweep();
    run_seq(5'd2, 5'd5, 1'b1, "sweep2_5");
    run_seq(5'd4, 5'd4, 1'b1, "sweep_eq");
  endtask

  task automatic test_random();
    logic [4:0] s, e;
    bit sw;
    for (int it = 0; it < 8; it++) begin
      stage_word(0, $urandom());
      stage_word(1, $urandom());
      s  = 5'($urandom_range(0, DEPTH - 1));
      sw = 1'($urandom_range(0, 1));
      e  = sw ? 5'($urandom_range(int'(s), DEPTH - 1)) : 5'($urandom_range(0, 31));
      run_seq(s, e, sw, "random");
    end
  endtask

  task automatic test_errors();
    logic [31:0] st;
    logic [4:0] s, e;
    bit sw, ok;
    do_reset();
    bus_write(6'h10, {15'd0, 1'b1, 3'd0, 5'd9, 3'd0, 5'd2});
    mdl_err = 1'b1;
    read_status(st);
    checks++;
    if (bus.busy !== 1'b0 || bus.latch_en !== '0 || st !== 32'h8000_0000) begin
      errors++;
      $display("FAIL end9 busy=%b le=%h st=%h expected 0 0 80000000", bus.busy, bus.latch_en, st);
    end
    bus_write(6'h14, 32'h0000_0000);
    read_status(st);
    checks++;
    if (st !== 32'h8000_0000) begin
      errors++;
      $display("FAIL w0_status got %h expected 80000000", st);
    end
    bus_write(6'h14, 32'h8000_0000);
    mdl_err = 1'b0;
    read_status(st);
    checks++;
    if (st !== 32'd0) begin
      errors++;
      $display("FAIL w1c got %h expected 0", st);
    end
    for (int it = 0; it < 10; it++) begin
      s  = 5'($urandom_range(0, 31));
      e  = 5'($urandom_range(0, 31));
      sw = 1'($urandom_range(0, 1));
      ok = sw ? (s <= e && e < DEPTH) : (s < DEPTH);
      if (ok) begin
        run_seq(s, e, sw, "rand_ctl");
      end else begin
        bus_write(6'h10, {15'd0, sw, 3'd0, e, 3'd0, s});
        mdl_err = 1'b1;
        read_status(st);
        checks++;
        if (bus.busy !== 1'b0 || st !== {1'b1, 1'b0, 25'd0, mdl_idx}) begin
          errors++;
          $display("FAIL bad_ctl s=%0d e=%0d sw=%0d busy=%b st=%h", s, e, sw, bus.busy, st);
        end
        bus_write(6'h14, 32'h8000_0000);
        mdl_err = 1'b0;
      end
    end
    bus_write(6'h10, 32'h8000_0000);
    bus_write(6'h3C, 32'hFFFF_FFFF);
    bus_write(6'h04, 32'hFFFF_FFFF);
    read_status(st);
    checks++;
    if (bus.busy !== 1'b0 || bus.config_data !== mdl_cfg() || st !== {7'd0, 25'd0} + 32'(mdl_idx)) begin
      errors++;
      $display("FAIL idle_noop busy=%b cfg=%h st=%h", bus.busy, bus.config_data, st);
    end
  endtask

  task automatic test_abort();
    logic [31:0] st;
    bus_write(6'h10, {15'd0, 1'b1, 3'd0, 5'd7, 3'd0, 5'd0});
    repeat (7) @(negedge clk);
    checks++;
    if (bus.latch_en !== 8'h20) begin
      errors++;
      $display("FAIL abort_pre le=%h expected 20", bus.latch_en);
    end
    bus_write(6'h10, 32'h8000_0000);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.latch_en !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL abort cyc%0d le=%h busy=%b done=%b expected 0 0 0",
                 i, bus.latch_en, bus.busy, bus.done);
      end
      @(negedge clk);
    end
    read_status(st);
    checks++;
    if (st[31] !== mdl_err) begin
      errors++;
      $display("FAIL abort_err got %b expected %b", st[31], mdl_err);
    end
  endtask

  task automatic test_busy_writes();
    logic [31:0] st;
    logic [WIDTH-1:0] cfg0;
    cfg0 = mdl_cfg();
    bus_write(6'h10, {27'd0, 5'd4});
    bus_write(6'h20, ~mdl_stage[0]);
    bus_write(6'h10, {27'd0, 5'd1});
    repeat (6) @(negedge clk);
    mdl_err = 1'b1;
    read_status(st);
    checks++;
    if (bus.config_data !== cfg0 || bus.busy !== 1'b0 || st !== {1'b1, 1'b0, 25'd0, 5'd4}) begin
      errors++;
      $display("FAIL busy_wr cfg=%h busy=%b st=%h expected cfg=%h st=%h",
               bus.config_data, bus.busy, st, cfg0, {1'b1, 1'b0, 25'd0, 5'd4});
    end
    bus_write(6'h14, 32'h8000_0000);
    mdl_err = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] st;
    bus_write(6'h10, {27'd0, 5'd3});
    @(negedge clk);
    checks++;
    if (bus.latch_en !== 8'h08) begin
      errors++;
      $display("FAIL pre_rst le=%h expected 08", bus.latch_en);
    end
    #2 rst_n = 1'b0;
    read_status(st);
    checks++;
    if (bus.latch_en !== '0 || bus.busy !== 1'b0 || bus.config_data !== '0 || st !== 32'd0) begin
      errors++;
      $display("FAIL async_rst le=%h busy=%b cfg=%h st=%h expected all zero",
               bus.latch_en, bus.busy, bus.config_data, st);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_stage[0] = '0; mdl_stage[1] = '0; mdl_err = 1'b0; mdl_idx = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.latch_en !== '0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL post_rst busy=%b le=%h done=%b expected idle", bus.busy, bus.latch_en, bus.done);
    end
    run_seq(5'd0, 5'd1, 1'b1, "post_rst");
  endtask

  initial begin
    bus.debug_wr = 1'b0;
    bus.address  = 6'h00;
    bus.data_in  = 32'd0;
    test_reset();
    test_single();
    test_sweep();
    test_random();
    test_errors();
    test_abort();
    test_busy_writes();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
